// File: rtl/vga_scramble_pkg.sv
// Constants and helpers shared by the VGA scrambler and descrambler.
// Both ends must step identical LFSRs from identical seeds.
package vga_scramble_pkg;

    localparam logic [11:0] KEY_SEED  = 12'hACE;
    localparam logic [11:0] KEY_TAPS  = 12'hE08;
    localparam logic [11:0] CODE_TAPS = 12'h829;

    typedef logic [11:0] rgb444_t;

    typedef enum logic {
        UNSYNC = 1'b0,
        RUN    = 1'b1
    } dscr_state_t;

    // Right-shift LFSR: feedback is the parity of the tapped bits, entering at bit 11.
    function automatic logic [11:0] lfsr12_next(input logic [11:0] s, input logic [11:0] taps);
        return {^(s & taps), s[11:1]};
    endfunction

endpackage

// File: rtl/vga_lfsr12.sv
// 12-bit LFSR with synchronous seed load (priority) and step enable.
// Holds its value when neither load nor step is asserted.
module vga_lfsr12
    import vga_scramble_pkg::*;
#(
    parameter logic [11:0] TAPS = CODE_TAPS
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        load,
    input  logic [11:0] seed,
    input  logic        step,
    output logic [11:0] state
);

    logic [11:0] state_q;
    logic [11:0] state_d;

    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = seed;
        end else if (step) begin
            state_d = lfsr12_next(state_q, TAPS);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= '0;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/vga_descrambler.sv
// Removes the key and code LFSR streams from a scrambled RGB444 pixel stream
// and reports lock once the code has stayed stable for LOCK_CYCLES after resync.
module vga_descrambler
    import vga_scramble_pkg::*;
#(
    parameter int LOCK_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [11:0] code,
    input  logic        resync,
    input  logic [3:0]  red_in,
    input  logic [3:0]  green_in,
    input  logic [3:0]  blue_in,
    output logic [3:0]  red_out,
    output logic [3:0]  green_out,
    output logic [3:0]  blue_out,
    output logic        locked
);

    localparam int            CW       = $clog2(LOCK_CYCLES + 1);
    localparam logic [CW-1:0] LOCK_MAX = CW'(LOCK_CYCLES);

    dscr_state_t   state_q;
    logic [CW-1:0] cnt_q;
    logic [11:0]   code_q;
    rgb444_t       out_q;
    logic          locked_q;

    rgb444_t       word_in;
    rgb444_t       key_s;
    rgb444_t       code_s;
    logic          run;
    logic          code_change;
    logic          step;

    assign word_in     = {red_in, green_in, blue_in};
    assign run         = (state_q == RUN);
    assign code_change = (code != code_q);
    // A code change drops to UNSYNC and freezes both streams until the next resync.
    assign step        = run && !resync && !code_change;

    vga_lfsr12 #(.TAPS(KEY_TAPS)) u_key_lfsr (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (resync),
        .seed    (KEY_SEED),
        .step    (step),
        .state   (key_s)
    );

    vga_lfsr12 #(.TAPS(CODE_TAPS)) u_code_lfsr (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (resync),
        .seed    (code),
        .step    (step),
        .state   (code_s)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= UNSYNC;
            cnt_q    <= '0;
            code_q   <= '0;
            out_q    <= '0;
            locked_q <= 1'b0;
        end else begin
            out_q <= run ? (word_in ^ key_s ^ code_s) : word_in;
            if (resync) begin
                state_q  <= RUN;
                code_q   <= code;
                cnt_q    <= '0;
                locked_q <= 1'b0;
            end else if (run && code_change) begin
                state_q  <= UNSYNC;
                locked_q <= 1'b0;
            end else if (run) begin
                if (cnt_q != LOCK_MAX) begin
                    cnt_q <= cnt_q + 1'b1;
                end
                locked_q <= (cnt_q == LOCK_MAX);
            end else begin
                locked_q <= 1'b0;
            end
        end
    end

    assign red_out   = out_q[11:8];
    assign green_out = out_q[7:4];
    assign blue_out  = out_q[3:0];
    assign locked    = locked_q;

endmodule

// File: tb/tb_vga_descrambler.sv
// Bench for vga_descrambler: driver pushes expected pixel/lock per cycle,
// monitor pops and compares one cycle later.
module tb_vga_descrambler;
    import vga_scramble_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        resync = 1'b0;
    logic [11:0] code = '0;
    logic [3:0]  red_in = '0, green_in = '0, blue_in = '0;
    logic [3:0]  red_out, green_out, blue_out;
    logic        locked;

    always #5 clk = ~clk;

    vga_descrambler #(.LOCK_CYCLES(16)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .code      (code),
        .resync    (resync),
        .red_in    (red_in),
        .green_in  (green_in),
        .blue_in   (blue_in),
        .red_out   (red_out),
        .green_out (green_out),
        .blue_out  (blue_out),
        .locked    (locked)
    );

    typedef struct {
        rgb444_t rgb;
        logic    lk;
        int      tid;
    } exp_t;

    exp_t    q[$];
    exp_t    m_e;
    int      n_vec = 0;
    int      n_err = 0;
    int      tid = 0;
    int      j = 0;
    rgb444_t ks = '0;
    rgb444_t cs = '0;
    rgb444_t w;

    // Monitor: one expected entry per driven cycle, checked after the capturing edge.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (q.size() > 0) begin
                m_e = q.pop_front();
                n_vec++;
                if ({red_out, green_out, blue_out} !== m_e.rgb || locked !== m_e.lk) begin
                    n_err++;
                    $display("FAIL test%0d out: got rgb=%h locked=%b, want rgb=%h locked=%b",
                             m_e.tid, {red_out, green_out, blue_out}, locked, m_e.rgb, m_e.lk);
                end
            end
        end
    end

    task automatic apply(input rgb444_t wi, input logic rs, input logic [11:0] cd,
                         input rgb444_t e, input logic elk);
        code = cd;
        resync = rs;
        {red_in, green_in, blue_in} = wi;
        q.push_back('{rgb: e, lk: elk, tid: tid});
    endtask

    task automatic cyc(input rgb444_t wi, input logic rs, input logic [11:0] cd,
                       input rgb444_t e, input logic elk);
        @(negedge clk);
        apply(wi, rs, cd, e, elk);
    endtask

    task automatic step_model();
        ks = lfsr12_next(ks, KEY_TAPS);
        cs = lfsr12_next(cs, CODE_TAPS);
    endtask

    // Reference scrambler: send p scrambled, expect p back, lock after 16 stable cycles.
    task automatic rt(input rgb444_t p, input logic [11:0] cd);
        j++;
        cyc(p ^ ks ^ cs, 1'b0, cd, p, (j >= 17));
        step_model();
    endtask

    task automatic sync_idle(input rgb444_t wi, input logic [11:0] cd);
        cyc(wi, 1'b1, cd, wi, 1'b0);
        ks = KEY_SEED;
        cs = cd;
        j = 0;
    endtask

    task automatic sync_run(input rgb444_t p, input logic [11:0] cd);
        cyc(p ^ ks ^ cs, 1'b1, cd, p, 1'b0);
        ks = KEY_SEED;
        cs = cd;
        j = 0;
    endtask

    initial begin
        // Test 3: after reset, no resync -> pass-through, never locked
        tid = 3;
        repeat (3) @(negedge clk);
        n_vec++;
        if ({red_out, green_out, blue_out} !== 12'h000 || locked !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: got rgb=%h locked=%b, want rgb=000 locked=0",
                     {red_out, green_out, blue_out}, locked);
        end
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            w = rgb444_t'($urandom());
            cyc(w, 1'b0, 12'h5A5, w, 1'b0);
        end

        // Test 1: first two outputs after resync with zero input
        tid = 1;
        sync_idle(12'h000, 12'h5A5);
        j = 1;
        cyc(12'h000, 1'b0, 12'h5A5, 12'hF6B, 1'b0);
        step_model();
        j = 2;
        cyc(12'h000, 1'b0, 12'h5A5, 12'hFB5, 1'b0);
        step_model();

        // Tests 2/4: rest of a 640-pixel line round trip, lock rises at cycle 17
        tid = 2;
        for (int i = 0; i < 638; i++) rt(rgb444_t'($urandom()), 12'h5A5);

        // Test 4: code change without resync -> unlock, then pass-through
        tid = 4;
        w = rgb444_t'($urandom());
        cyc(w ^ ks ^ cs, 1'b0, 12'h123, w, 1'b0);
        for (int i = 0; i < 8; i++) begin
            w = rgb444_t'($urandom());
            cyc(w, 1'b0, 12'h123, w, 1'b0);
        end

        // Test 5: resync from UNSYNC, then resync + code change together while in RUN
        tid = 5;
        sync_idle(rgb444_t'($urandom()), 12'h123);
        for (int i = 0; i < 30; i++) rt(rgb444_t'($urandom()), 12'h123);
        sync_run(rgb444_t'($urandom()), 12'h7E1);
        for (int i = 0; i < 40; i++) rt(rgb444_t'($urandom()), 12'h7E1);

        // Test 6: async reset mid-line, then release with resync in the same cycle
        tid = 6;
        for (int i = 0; i < 10; i++) rt(rgb444_t'($urandom()), 12'h7E1);
        @(posedge clk);
        #4;
        reset_n = 1'b0;
        #1;
        n_vec++;
        if ({red_out, green_out, blue_out} !== 12'h000 || locked !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset: got rgb=%h locked=%b, want rgb=000 locked=0",
                     {red_out, green_out, blue_out}, locked);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        w = rgb444_t'($urandom());
        apply(w, 1'b1, 12'h7E1, w, 1'b0);
        ks = KEY_SEED;
        cs = 12'h7E1;
        j = 0;
        for (int i = 0; i < 60; i++) rt(rgb444_t'($urandom()), 12'h7E1);

        @(negedge clk);
        resync = 1'b0;
        @(posedge clk);
        #3;
        n_vec++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
